// File: rtl/cpu_oci_trace_capture.sv
// cpu_oci_trace_capture
//   Capture buffer for OCI debug-trace (DCT) words. Strobed trace words and
//   their fragment counts go into a show-ahead FIFO, which drains over a
//   valid/ready port. On test_ending, capture stops, the FIFO drains, and a
//   sticky test_has_ended flag is raised.
//
// Ports
//   clk, reset      : single rising-edge clock, synchronous active-high reset
//   dct_valid       : capture strobe for dct_buffer / dct_count
//   dct_buffer      : trace word (DATA_W)
//   dct_count       : fragments in the word; 0 means an empty word (ignored)
//   test_ending     : request end of capture (level or pulse)
//   out_data/count  : head-of-FIFO word and count (zero while empty)
//   out_valid       : FIFO not empty
//   out_ready       : sink accepts the head when out_valid=1
//   fill_level      : entries held, 0..DEPTH
//   overflow_cnt    : dropped/evicted words, saturating
//   test_has_ended  : sticky end-of-test flag
module cpu_oci_trace_capture #(
    parameter int unsigned DATA_W    = 30,
    parameter int unsigned COUNT_W   = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned OVERWRITE = 0,
    parameter int unsigned OVF_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dct_valid,
    input  logic [DATA_W-1:0]  dct_buffer,
    input  logic [COUNT_W-1:0] dct_count,
    input  logic               test_ending,
    output logic [DATA_W-1:0]  out_data,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W:0]    fill_level,
    output logic [OVF_W-1:0]   overflow_cnt,
    output logic               test_has_ended
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_ENDED
    } state_t;

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic            OVW      = (OVERWRITE != 0);

    state_t             r_state;
    logic [DATA_W-1:0]  r_mem_data [DEPTH];
    logic [COUNT_W-1:0] r_mem_cnt  [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W:0]    r_fill;
    logic [OVF_W-1:0]   r_ovf;
    logic               r_ended;

    logic w_valid;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_ovf;
    logic w_wr;
    logic w_rd_adv;

    always_comb begin
        w_valid  = (r_fill != '0);
        w_full   = (r_fill == FULL_LVL);
        w_push   = (r_state == ST_RUN) && dct_valid && (dct_count != '0);
        w_pop    = w_valid && out_ready;
        // A push into a full FIFO only overflows when no pop frees a slot.
        w_ovf    = w_push && w_full && !w_pop;
        w_wr     = w_push && (!w_ovf || OVW);
        // In overwrite mode an overflowing push evicts the oldest entry.
        w_rd_adv = w_pop || (w_ovf && OVW);
    end

    // Storage needs no reset: entries are only visible while counted by r_fill.
    always_ff @(posedge clk) begin
        if (w_wr && !reset) begin
            r_mem_data[r_wr_ptr] <= dct_buffer;
            r_mem_cnt[r_wr_ptr]  <= dct_count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_ovf    <= '0;
            r_ended  <= 1'b0;
            r_state  <= ST_RUN;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Eviction pairs a write with a read advance, leaving occupancy unchanged.
            if (w_wr && !w_rd_adv) begin
                r_fill <= r_fill + 1'b1;
            end else if (!w_wr && w_rd_adv) begin
                r_fill <= r_fill - 1'b1;
            end
            if (w_ovf && (r_ovf != '1)) begin
                r_ovf <= r_ovf + 1'b1;
            end

            case (r_state)
                ST_RUN: begin
                    if (test_ending) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_fill == '0) begin
                        r_state <= ST_ENDED;
                        r_ended <= 1'b1;
                    end
                end
                ST_ENDED: begin
                    r_ended <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        out_valid      = w_valid;
        out_data       = w_valid ? r_mem_data[r_rd_ptr] : '0;
        out_count      = w_valid ? r_mem_cnt[r_rd_ptr]  : '0;
        fill_level     = r_fill;
        overflow_cnt   = r_ovf;
        test_has_ended = r_ended;
    end

endmodule

// File: doc/cpu_oci_trace_capture.md
Name: cpu_oci_trace_capture

Overview:
- Parametrised capture buffer for OCI debug-trace (DCT) words, with drain and end-of-test sequencing.
- Accepts strobed trace words plus their fragment count into a show-ahead FIFO, and drains them over a valid/ready port to a simulation monitor or on-chip sink.
- On test_ending, stops capture, drains what remains, then asserts a sticky test_has_ended.
- Instantiated per CPU alongside the OCI debug module; generalises the fixed 30-bit, 4-bit-count, capture-less test-bench shell.

Parameters:
- DATA_W, 30, width of dct_buffer / out_data.
- COUNT_W, 4, width of dct_count / out_count.
- DEPTH, 16, FIFO entries; must be a power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).
- OVERWRITE, 0, 0 = drop incoming word when full; 1 = evict oldest entry when full.
- OVF_W, 16, width of overflow_cnt.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- dct_valid  in  1  capture strobe for dct_buffer/dct_count.
- dct_buffer  in  DATA_W  trace word.
- dct_count  in  COUNT_W  valid fragments in word; 0 = empty word.
- test_ending  in  1  level/pulse; request end of capture.
- out_data  out  DATA_W  head-of-FIFO word.
- out_count  out  COUNT_W  head-of-FIFO count.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  sink accepts head when out_valid=1.
- fill_level  out  ADDR_W+1  entries held, 0..DEPTH.
- overflow_cnt  out  OVF_W  dropped/evicted words, saturating.
- test_has_ended  out  1  sticky end-of-test flag.

Behaviour:
- Reset (sync, active-high; wins over every other input in that cycle):
  - Pointers = 0, fill_level = 0, out_valid = 0, out_data = 0, out_count = 0, overflow_cnt = 0, test_has_ended = 0, state = RUN.
  - Reset mid-drain discards all contents.
- Push condition: state==RUN and dct_valid=1 and dct_count!=0. A word with dct_count==0 is ignored, not counted.
- Pop condition: out_valid=1 and out_ready=1. The head advances on the next edge.
- Latency: word pushed on edge N appears on out_* with out_valid=1 after edge N (one cycle) when the FIFO was empty.
- Output ordering: strict FIFO. out_data/out_count are stable while out_valid=1 and out_ready=0.
- Full without pop:
  - OVERWRITE=0: push is dropped; overflow_cnt increments.
  - OVERWRITE=1: oldest entry is evicted (rd ptr advances), new word is written, fill_level stays DEPTH, overflow_cnt increments.
- Full with simultaneous pop: push accepted, no overflow, fill_level unchanged.
- Empty with simultaneous push: no pop is possible (out_valid=0); fill_level becomes 1.
- overflow_cnt saturates at 2^OVF_W-1.
- Pointers are ADDR_W bits and wrap modulo DEPTH. fill_level tracks occupancy separately.
- State machine:
  - RUN: capture enabled. test_ending=1 moves to DRAIN on the next edge. A push in that same cycle is still accepted.
  - DRAIN: pushes are ignored; pops continue. When fill_level==0, moves to ENDED.
  - ENDED: test_has_ended=1, held until reset. dct_valid and test_ending are ignored.
  - test_ending asserted while already in DRAIN or ENDED has no effect.
  - test_ending with an empty FIFO: RUN -> DRAIN -> ENDED. test_has_ended rises 2 cycles after the sampling edge.
- No combinational path from dct_* to out_*. out_ready may combinationally affect nothing except the next-state logic.

Test Plan:
- Reset then push 3 words (0x0000001/cnt 1, 0x0000002/cnt 2, 0x3FFFFFFF/cnt 15), out_ready=1 -> out_valid rises 1 cycle after the first push; words exit in order; fill_level returns to 0; overflow_cnt=0.
- out_ready=0, OVERWRITE=0, push 18 words valued 1..18 -> fill_level=16, overflow_cnt=2; drain yields 1..16.
- Same stimulus with OVERWRITE=1 -> fill_level=16, overflow_cnt=2; drain yields 3..18.
- FIFO full, out_ready=1 and dct_valid=1 in the same cycle -> no overflow; fill_level stays 16; the popped word is the oldest.
- Hold 5 words with out_ready=0, pulse test_ending with dct_valid=1 and word 0xAA -> 6 entries held; later pushes ignored; after raising out_ready, all 6 drain and test_has_ended rises the cycle after fill_level hits 0, then stays high.
- Assert reset mid-DRAIN with 4 entries held -> next cycle fill_level=0, out_valid=0, test_has_ended=0, capture re-enabled; dct_count==0 pushes never enter the FIFO.
